// File: rtl/jtkicker_arb_pkg.sv
// jtkicker_arb_pkg: shared widths, FSM states and the
// round-robin helper for the Kicker SDRAM read arbiter.
package jtkicker_arb_pkg;
  localparam int NSLOT = 4;
  localparam int AW = 22;
  localparam int DW = 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  // k-th slot (k=1..3) visited after ptr in the 1..3 ring
  function automatic logic [1:0] rr_slot(
    input logic [1:0] ptr,
    input logic [1:0] k
  );
    logic [2:0] t;
    t = {1'b0, ptr} + {1'b0, k} - 3'd1;
    if (t >= 3'd3) t = t - 3'd3;
    return t[1:0] + 2'd1;
  endfunction
endpackage

// File: rtl/jtkicker_sdram_arb_if.sv
// jtkicker_sdram_arb_if: SDRAM controller side of the arbiter.
// master = arbiter (req/addr out), slave = controller (ack/data out).
interface jtkicker_sdram_arb_if;
  import jtkicker_arb_pkg::*;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          data_dst;
  logic          data_rdy;
  logic [DW-1:0] data_read;

  modport master (
    output sdram_req, sdram_addr,
    input  sdram_ack, data_dst, data_rdy, data_read
  );
  modport slave (
    input  sdram_req, sdram_addr,
    output sdram_ack, data_dst, data_rdy, data_read
  );
endinterface

// File: rtl/jtkicker_arb_slot.sv
// jtkicker_arb_slot: one-word cache per requester. Ports: cs/addr in,
// need/ok/dout out, fill (we/fill_addr/fill_data), clr. JTKICKER_ARB_KEEP_EN.
module jtkicker_arb_slot
  import jtkicker_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic          need,
  output logic          ok,
  output logic [DW-1:0] dout
);
  logic [AW-1:0] tag;
  logic [DW-1:0] data;
  logic          valid;
  logic          rise;
  logic          hit;
  logic          fill_hit;

`ifdef JTKICKER_ARB_KEEP_EN
  assign rise = 1'b0;
`else
  logic cs_d;
  always_ff @(posedge clk) begin
    if (rst) cs_d <= 1'b0;
    else     cs_d <= cs;
  end
  // a fresh request never trusts the old entry
  assign rise = cs & ~cs_d;
`endif

  assign hit = cs & valid & ~rise & ~clr & (tag == addr);
  // bypass so ok rises the cycle after data_rdy
  assign fill_hit = cs & we & ~clr & (fill_addr == addr);
  assign need = cs & ~hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
      ok    <= 1'b0;
      dout  <= '0;
    end else begin
      if (we) begin
        tag  <= fill_addr;
        data <= fill_data;
      end
      if (clr)       valid <= 1'b0;
      else if (we)   valid <= 1'b1;
      else if (rise) valid <= 1'b0;
      ok   <= hit | fill_hit;
      dout <= we ? fill_data : data;
    end
  end
endmodule

// File: rtl/jtkicker_sdram_arb.sv
// jtkicker_sdram_arb: 4-slot SDRAM read arbiter, slot 0 fixed priority,
// slots 1-3 round-robin. Ports: clk, rst, downloading, slotN_*, bus.
module jtkicker_sdram_arb
  import jtkicker_arb_pkg::*;
#(
  parameter logic [AW-1:0] SLOT0_OFFSET = 22'h0,
  parameter logic [AW-1:0] SLOT1_OFFSET = 22'h0,
  parameter logic [AW-1:0] SLOT2_OFFSET = 22'h0,
  parameter logic [AW-1:0] SLOT3_OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          slot0_cs,
  input  logic [AW-1:0] slot0_addr,
  output logic          slot0_ok,
  output logic [DW-1:0] slot0_dout,
  input  logic          slot1_cs,
  input  logic [AW-1:0] slot1_addr,
  output logic          slot1_ok,
  output logic [DW-1:0] slot1_dout,
  input  logic          slot2_cs,
  input  logic [AW-1:0] slot2_addr,
  output logic          slot2_ok,
  output logic [DW-1:0] slot2_dout,
  input  logic          slot3_cs,
  input  logic [AW-1:0] slot3_addr,
  output logic          slot3_ok,
  output logic [DW-1:0] slot3_dout,
  jtkicker_sdram_arb_if.master bus
);
  logic [NSLOT-1:0] cs, need, ok, inflight, cand, we;
  logic [AW-1:0]    addr [NSLOT];
  logic [AW-1:0]    offs [NSLOT];
  logic [DW-1:0]    dout [NSLOT];

  state_t        st, st_nx;
  logic [1:0]    gnt, gnt_nx, rr_ptr, s;
  logic          gnt_vld, take, fill;
  logic [AW-1:0] fetch_addr, req_addr;
  logic          req_q;
  logic          unused_dst;

  assign cs = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign addr[0] = slot0_addr;
  assign addr[1] = slot1_addr;
  assign addr[2] = slot2_addr;
  assign addr[3] = slot3_addr;
  assign offs[0] = SLOT0_OFFSET;
  assign offs[1] = SLOT1_OFFSET;
  assign offs[2] = SLOT2_OFFSET;
  assign offs[3] = SLOT3_OFFSET;
  assign {slot3_ok, slot2_ok, slot1_ok, slot0_ok} = ok;
  assign slot0_dout = dout[0];
  assign slot1_dout = dout[1];
  assign slot2_dout = dout[2];
  assign slot3_dout = dout[3];

  assign fill = (st == WAIT) & bus.data_rdy;
  assign take = (st == IDLE) & ~downloading & gnt_vld;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = req_addr;
  assign unused_dst = bus.data_dst;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    assign we[i] = fill & (gnt == 2'(i));
    jtkicker_arb_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .cs        (cs[i]),
      .addr      (addr[i]),
      .clr       (downloading),
      .we        (we[i]),
      .fill_addr (fetch_addr),
      .fill_data (bus.data_read),
      .need      (need[i]),
      .ok        (ok[i]),
      .dout      (dout[i])
    );
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NSLOT; i++)
      inflight[i] = (st != IDLE) && (gnt == 2'(i));
    cand = need & ~inflight;
    gnt_vld = 1'b0;
    gnt_nx = gnt;
    s = 2'd0;
    if (cand[0]) begin
      gnt_vld = 1'b1;
      gnt_nx = 2'd0;
    end else begin
      // descending so the earliest slot in ring order wins
      for (int k = 3; k >= 1; k--) begin
        s = rr_slot(rr_ptr, 2'(k));
        if (cand[s]) begin
          gnt_vld = 1'b1;
          gnt_nx = s;
        end
      end
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (take) st_nx = REQ;
      REQ:     if (bus.sdram_ack) st_nx = WAIT;
      WAIT:    if (bus.data_rdy) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      gnt        <= 2'd0;
      rr_ptr     <= 2'd0;
      fetch_addr <= '0;
      req_q      <= 1'b0;
      req_addr   <= '0;
    end else begin
      st <= st_nx;
      if (take) begin
        gnt        <= gnt_nx;
        fetch_addr <= addr[gnt_nx];
        req_q      <= 1'b1;
        req_addr   <= addr[gnt_nx] + offs[gnt_nx];
        if (gnt_nx != 2'd0) rr_ptr <= gnt_nx;
      end
      if ((st == REQ) && bus.sdram_ack) req_q <= 1'b0;
    end
  end
endmodule
